// File: rtl/mux_seq_n_1.sv
// N-to-1 symbol-code multiplexer with a manual-select mode and a scan mode
// that emits a snapshot of channels 1..len one code per consumer acknowledge.
//
// state | meaning
// IDLE  | manual select (modo=0) or waiting for a scan start (modo=1)
// EMIT  | scan in progress, salida driven from the start-time snapshot
module mux_seq_n_1 #(
  parameter int W  = 5,
  parameter int N  = 12,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  entradas,
  input  logic            modo,
  input  logic [CW-1:0]   sel,
  input  logic            start,
  input  logic [CW-1:0]   len,
  input  logic            avance,
  output logic [W-1:0]    salida,
  output logic            valido,
  output logic            ocupado,
  output logic            fin,
  output logic [CW-1:0]   idx
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [CW-1:0] N_IDX = CW'(N);

  state_t         state_q, state_d;
  logic [N*W-1:0] snap_q, snap_d;
  logic [CW-1:0]  last_q, last_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [W-1:0]   salida_q, salida_d;
  logic           valido_q, valido_d;
  logic           fin_q, fin_d;

  // Channel k lives at bits [k*W-1:(k-1)*W]; out-of-range indices give 0.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] v, input logic [CW-1:0] i);
    logic [W-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      if (i == CW'(k)) r = v[k*W-1 -: W];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    last_d   = last_q;
    idx_d    = idx_q;
    salida_d = salida_q;
    valido_d = valido_q;
    fin_d    = 1'b0;
    case (state_q)
      IDLE: begin
        salida_d = '0;
        valido_d = 1'b0;
        idx_d    = '0;
        if (!modo) begin
          if (sel != '0 && sel <= N_IDX) begin
            salida_d = pick(entradas, sel);
            valido_d = 1'b1;
            idx_d    = sel;
          end
        end else if (start) begin
          if (len == '0) begin
            fin_d = 1'b1;
          end else begin
            snap_d   = entradas;
            last_d   = (len > N_IDX) ? N_IDX : len;
            idx_d    = CW'(1);
            salida_d = pick(entradas, CW'(1));
            valido_d = 1'b1;
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        if (avance) begin
          if (idx_q < last_q) begin
            idx_d    = idx_q + CW'(1);
            salida_d = pick(snap_q, idx_q + CW'(1));
          end else begin
            state_d  = IDLE;
            idx_d    = '0;
            salida_d = '0;
            valido_d = 1'b0;
            fin_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      salida_q <= '0;
      valido_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      salida_q <= salida_d;
      valido_q <= valido_d;
      fin_q    <= fin_d;
    end
  end

  assign salida  = salida_q;
  assign valido  = valido_q;
  assign idx     = idx_q;
  assign fin     = fin_q;
  assign ocupado = (state_q == EMIT);

endmodule

// File: tb/tb_mux_seq_n_1.sv
// Self-checking bench for mux_seq_n_1: manual-sweep vector table, directed scan
// sequences and a random run against a queue-based reference model.
module tb_mux_seq_n_1;
  localparam int W  = 5;
  localparam int N  = 12;
  localparam int CW = 4;

  logic            clk;
  logic            rst;
  logic [N*W-1:0]  entradas;
  logic            modo;
  logic [CW-1:0]   sel;
  logic            start;
  logic [CW-1:0]   len;
  logic            avance;
  logic [W-1:0]    salida;
  logic            valido;
  logic            ocupado;
  logic            fin;
  logic [CW-1:0]   idx;

  mux_seq_n_1 #(.W(W), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .entradas(entradas), .modo(modo), .sel(sel),
    .start(start), .len(len), .avance(avance), .salida(salida),
    .valido(valido), .ocupado(ocupado), .fin(fin), .idx(idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a scan is a queue of snapshot codes consumed per acknowledge.
  logic [W-1:0] mq[$];
  bit           m_busy;
  logic [W-1:0] m_sal;
  bit           m_val;
  int           m_idx;
  bit           m_fin;

  typedef struct {
    logic [CW-1:0] sel;
    logic [W-1:0]  exp_salida;
    logic          exp_valido;
    logic [CW-1:0] exp_idx;
  } vec_t;
  vec_t vec[16];

  function automatic logic [W-1:0] ch(input logic [N*W-1:0] v, input int k);
    return v[k*W-1 -: W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int n;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_sal = '0; m_val = 0; m_idx = 0; m_fin = 0;
    end else if (!m_busy) begin
      m_fin = 0; m_sal = '0; m_val = 0; m_idx = 0;
      if (!modo) begin
        if (sel >= 1 && int'(sel) <= N) begin
          m_sal = ch(entradas, int'(sel)); m_val = 1; m_idx = int'(sel);
        end
      end else if (start) begin
        if (len == 0) begin
          m_fin = 1;
        end else begin
          n = (int'(len) > N) ? N : int'(len);
          mq.delete();
          for (int k = 1; k <= n; k++) mq.push_back(ch(entradas, k));
          m_sal = mq[0]; m_val = 1; m_idx = 1; m_busy = 1;
        end
      end
    end else begin
      m_fin = 0;
      if (avance) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy = 0; m_sal = '0; m_val = 0; m_idx = 0; m_fin = 1;
        end else begin
          m_sal = mq[0]; m_idx++;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_salida", 32'(salida), 32'(m_sal));
    chk("model_valido", 32'(valido), 32'(m_val));
    chk("model_idx", 32'(idx), 32'(m_idx));
    chk("model_fin", 32'(fin), 32'(m_fin));
    chk("model_ocupado", 32'(ocupado), 32'(m_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic load_ramp();
    for (int k = 1; k <= N; k++) entradas[k*W-1 -: W] = W'(k);
  endtask

  logic [63:0] r64;

  initial begin
    rst = 1'b1; entradas = '0; modo = 1'b0; sel = '0; start = 1'b0; len = '0; avance = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec[i].sel        = CW'(i);
      vec[i].exp_valido = (i >= 1 && i <= N);
      vec[i].exp_salida = (i >= 1 && i <= N) ? W'(31 - i) : '0;
      vec[i].exp_idx    = (i >= 1 && i <= N) ? CW'(i) : '0;
    end

    tick();
    tick();
    chk("reset_salida", 32'(salida), 0);
    chk("reset_valido", 32'(valido), 0);
    chk("reset_ocupado", 32'(ocupado), 0);
    chk("reset_fin", 32'(fin), 0);
    chk("reset_idx", 32'(idx), 0);
    rst = 1'b0;

    // Manual sweep over every index value
    for (int k = 1; k <= N; k++) entradas[k*W-1 -: W] = W'(31 - k);
    modo = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel = vec[i].sel;
      tick();
      chk("sweep_salida", 32'(salida), 32'(vec[i].exp_salida));
      chk("sweep_valido", 32'(valido), 32'(vec[i].exp_valido));
      chk("sweep_idx", 32'(idx), 32'(vec[i].exp_idx));
    end

    // Full scan len=3 with avance held
    load_ramp();
    modo = 1'b1; len = CW'(3); start = 1'b1; avance = 1'b1;
    tick();
    chk("scan3_first", 32'(salida), 1);
    chk("scan3_ocupado", 32'(ocupado), 1);
    start = 1'b0;
    tick();
    chk("scan3_second", 32'(salida), 2);
    tick();
    chk("scan3_third", 32'(salida), 3);
    chk("scan3_idx3", 32'(idx), 3);
    tick();
    chk("scan3_fin", 32'(fin), 1);
    chk("scan3_ocupado_fall", 32'(ocupado), 0);
    chk("scan3_valido_fall", 32'(valido), 0);
    tick();
    chk("scan3_fin_once", 32'(fin), 0);

    // Stall with changing inputs: snapshot must hold
    avance = 1'b0; len = CW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r64 = {$urandom(), $urandom()};
      entradas = r64[N*W-1:0];
      tick();
      chk("stall_salida", 32'(salida), 1);
      chk("stall_idx", 32'(idx), 1);
    end
    avance = 1'b1;
    tick();
    chk("stall_second", 32'(salida), 2);
    avance = 1'b0;
    tick();
    chk("stall_hold", 32'(salida), 2);
    avance = 1'b1;
    tick();
    chk("stall_fin", 32'(fin), 1);
    avance = 1'b0;

    // Clamp len=15 to 12, then len=0 immediately after fin
    load_ramp();
    len = CW'(15); start = 1'b1; avance = 1'b1;
    tick();
    chk("clamp_first", 32'(salida), 1);
    start = 1'b0;
    for (int j = 2; j <= N; j++) begin
      tick();
      chk("clamp_code", 32'(salida), 32'(j));
    end
    tick();
    chk("clamp_fin", 32'(fin), 1);
    chk("clamp_idx0", 32'(idx), 0);
    len = '0; start = 1'b1;
    tick();
    chk("zero_fin", 32'(fin), 1);
    chk("zero_valido", 32'(valido), 0);
    chk("zero_ocupado", 32'(ocupado), 0);
    start = 1'b0;
    tick();
    chk("zero_fin_once", 32'(fin), 0);
    chk("zero_valido2", 32'(valido), 0);

    // Start ignored while busy, then abort by reset
    len = CW'(5); start = 1'b1; avance = 1'b0;
    tick();
    start = 1'b0; avance = 1'b1;
    tick();
    chk("abort_idx2", 32'(idx), 2);
    avance = 1'b0; start = 1'b1; modo = 1'b0; sel = CW'(7);
    tick();
    chk("busy_start_ignored", 32'(idx), 2);
    chk("busy_salida_hold", 32'(salida), 2);
    modo = 1'b1; start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_salida", 32'(salida), 0);
    chk("abort_valido", 32'(valido), 0);
    chk("abort_ocupado", 32'(ocupado), 0);
    chk("abort_fin", 32'(fin), 0);
    chk("abort_idx", 32'(idx), 0);
    tick();
    chk("abort_no_fin", 32'(fin), 0);

    // Random run against the model
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      modo   = ($urandom_range(0, 3) != 0);
      sel    = CW'($urandom_range(0, 15));
      start  = ($urandom_range(0, 3) == 0);
      len    = CW'($urandom_range(0, 15));
      avance = $urandom_range(0, 1) == 1;
      r64 = {$urandom(), $urandom()};
      entradas = r64[N*W-1:0];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_seq_n_1.md
MUX_SEQ_N_1 -- requirements
Module: mux_seq_n_1

Interface
REQ-001 Parameter W, default 5, bit width of one symbol code.
REQ-002 Parameter N, default 12, number of input channels (1..N addressable; N >= 1).
REQ-003 Parameter CW, default 4, index width; the integrator SHALL set it so that 2^CW >= N+1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 entradas  in  N*W  packed channel codes; channel k (1..N) occupies bits [k*W-1:(k-1)*W].
REQ-007 modo  in  1  0 = manual select, 1 = scan (sequencer).
REQ-008 sel  in  CW  manual-mode channel index.
REQ-009 start  in  1  scan-mode start request, level-sampled.
REQ-010 len  in  CW  scan-mode number of channels to emit, starting at channel 1.
REQ-011 avance  in  1  consumer acknowledge; advances the sequence when valido=1.
REQ-012 salida  out  W  registered selected code.
REQ-013 valido  out  1  salida holds a legal channel code.
REQ-014 ocupado  out  1  scan in progress.
REQ-015 fin  out  1  one-cycle pulse at scan completion.
REQ-016 idx  out  CW  registered index of the channel on salida (0 when none).

Function
REQ-017 FSM states: IDLE, EMIT; ocupado SHALL be 1 exactly while in EMIT.
REQ-018 IDLE, modo=0: each cycle salida <= slice(sel), idx <= sel, valido <= 1 if 1<=sel<=N; for sel=0 or sel>N, salida <= 0, idx <= 0, valido <= 0 (latency 1 cycle).
REQ-019 IDLE, modo=1, start=0: salida <= 0, valido <= 0, idx <= 0.
REQ-020 IDLE, modo=1, start=1, len=0: fin pulses next cycle, state stays IDLE, valido=0.
REQ-021 IDLE, modo=1, start=1, len>=1: capture entradas into internal snapshot, capture min(len,N) as last index, idx <= 1, salida <= snapshot slice 1, valido <= 1, enter EMIT (first code visible 1 cycle after start).
REQ-022 EMIT: salida SHALL come from the snapshot only; entradas changes after start SHALL have no effect until next start.
REQ-023 EMIT, avance=0: salida, idx, valido hold.
REQ-024 EMIT, avance=1, idx<last: idx <= idx+1, salida <= snapshot slice idx+1 next cycle; one code per acknowledge, no skips, no repeats.
REQ-025 EMIT, avance=1, idx=last: next cycle state IDLE, valido=0, salida=0, idx=0, ocupado=0, fin=1 for exactly one cycle.
REQ-026 start in EMIT SHALL be ignored; modo and sel changes in EMIT SHALL be ignored until IDLE.
REQ-027 avance in IDLE SHALL be ignored.
REQ-028 start and final avance never coincide in one state; start asserted on the cycle after fin SHALL launch a new scan normally.
REQ-029 len>N SHALL be clamped to N; idx never exceeds N and never wraps.

Reset
REQ-030 rst=1 at a clock edge SHALL force: state IDLE, salida=0, valido=0, ocupado=0, fin=0, idx=0, snapshot cleared; rst dominates all other inputs.
REQ-031 rst asserted mid-scan SHALL abort without fin pulse; first post-reset cycle behaves per REQ-018/019.

Verification (N=12, W=5)
REQ-032 Manual sweep: modo=0, sel=0..15 -> one cycle later salida = slice(sel) for 1..12 with valido=1; salida=0, valido=0 for 0,13,14,15.
REQ-033 Full scan: entradas slice k = k, start with len=3, avance held 1 -> salida 1,2,3 on consecutive cycles, then fin=1 one cycle, ocupado falls same cycle.
REQ-034 Stall and snapshot: len=2, avance=0 for 5 cycles while entradas changes -> salida stays original slice 1; then avance pulses -> original slice 2, then fin.
REQ-035 Clamp and zero: len=15 -> 12 codes then fin; len=0 -> fin next cycle, valido never 1.
REQ-036 Abort: rst at idx=2 of len=5 scan -> next cycle all outputs 0, no fin; start ignored while ocupado=1 verified by unchanged idx.
